// File: rtl/eye_tracker_reg_bank.sv
// Host register bank for the EyeTracker datapath: control registers, VSYNC-coherent
// status snapshots with a multi-byte read lock, and W1C sticky events driving an IRQ.
module eye_tracker_reg_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CTRL   = 4,
  parameter logic [NUM_CTRL*DATA_WIDTH-1:0] CTRL_INIT = 32'h0101_0100,
  parameter int NUM_STAT   = 7,
  parameter int STAT_WIDTH = 28,
  parameter int NUM_EVT    = 4,
  localparam int BYTES     = (STAT_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH,
  localparam int REG_COUNT = NUM_CTRL + NUM_STAT*BYTES + 2
) (
  input  logic                           CLK,
  input  logic                           RST_N,
  input  logic [REG_COUNT-1:0]           iWE_BIT,
  input  logic [REG_COUNT-1:0]           iRE_BIT,
  input  logic [DATA_WIDTH-1:0]          iDATA,
  output logic [DATA_WIDTH-1:0]          oRD,
  output logic                           oRD_VALID,
  input  logic                           iVSYNC,
  input  logic [NUM_STAT*STAT_WIDTH-1:0] iSTAT,
  input  logic [NUM_EVT-1:0]             iEVT,
  output logic [NUM_CTRL*DATA_WIDTH-1:0] oCTRL,
  output logic                           oIRQ
);

  localparam int STAT_BASE    = NUM_CTRL;
  localparam int EVT_STAT_IDX = REG_COUNT - 2;
  localparam int EVT_EN_IDX   = REG_COUNT - 1;
  localparam int PAD_W        = BYTES * DATA_WIDTH;
  localparam int IDX_W        = (NUM_STAT > 1) ? $clog2(NUM_STAT) : 1;

  logic [DATA_WIDTH-1:0] r_ctrl   [NUM_CTRL];
  logic [STAT_WIDTH-1:0] r_shadow [NUM_STAT];
  logic [PAD_W-1:0]      w_shadow_pad [NUM_STAT];
  logic                  r_lock;
  logic [IDX_W-1:0]      r_lock_idx;
  logic                  r_pending;
  logic                  r_vsync_d;
  logic [NUM_EVT-1:0]    r_evt_stat;
  logic [NUM_EVT-1:0]    r_evt_en;
  logic [DATA_WIDTH-1:0] r_rd;
  logic                  r_rd_valid;
  logic                  r_irq;

  logic [DATA_WIDTH-1:0] w_rd;
  logic                  w_edge;
  logic                  w_load;
  logic                  w_lock_set;
  logic [IDX_W-1:0]      w_lock_set_idx;
  logic                  w_lock_clr;
  logic [NUM_EVT-1:0]    w_evt_clr;
  logic                  w_unused_stat_we;

  // Status indices are read-only; their write strobes are intentionally dropped.
  assign w_unused_stat_we = |iWE_BIT[STAT_BASE +: NUM_STAT*BYTES];

  for (genvar k = 0; k < NUM_CTRL; k++) begin : g_ctrl_out
    assign oCTRL[k*DATA_WIDTH +: DATA_WIDTH] = r_ctrl[k];
  end

  for (genvar s = 0; s < NUM_STAT; s++) begin : g_pad
    assign w_shadow_pad[s] = PAD_W'(r_shadow[s]);
  end

  always_comb begin
    w_rd = '0;
    for (int k = 0; k < NUM_CTRL; k++) begin
      if (iRE_BIT[k]) w_rd = w_rd | r_ctrl[k];
    end
    for (int s = 0; s < NUM_STAT; s++) begin
      for (int b = 0; b < BYTES; b++) begin
        if (iRE_BIT[STAT_BASE + s*BYTES + b])
          w_rd = w_rd | w_shadow_pad[s][b*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (iRE_BIT[EVT_STAT_IDX]) w_rd = w_rd | DATA_WIDTH'(r_evt_stat);
    if (iRE_BIT[EVT_EN_IDX])   w_rd = w_rd | DATA_WIDTH'(r_evt_en);
  end

  // A byte-0 read takes (or re-takes) the lock; only the top byte of the locked word releases it.
  always_comb begin
    w_lock_set     = 1'b0;
    w_lock_set_idx = '0;
    w_lock_clr     = 1'b0;
    for (int s = 0; s < NUM_STAT; s++) begin
      if (iRE_BIT[STAT_BASE + s*BYTES]) begin
        w_lock_set     = 1'b1;
        w_lock_set_idx = IDX_W'(s);
      end
      if (iRE_BIT[STAT_BASE + s*BYTES + BYTES - 1] && (r_lock_idx == IDX_W'(s)))
        w_lock_clr = 1'b1;
    end
  end

  assign w_edge    = iVSYNC & ~r_vsync_d;
  assign w_load    = ~r_lock & (w_edge | r_pending);
  assign w_evt_clr = iWE_BIT[EVT_STAT_IDX] ? iDATA[NUM_EVT-1:0] : '0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < NUM_CTRL; k++) r_ctrl[k] <= CTRL_INIT[k*DATA_WIDTH +: DATA_WIDTH];
      for (int s = 0; s < NUM_STAT; s++) r_shadow[s] <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_pending  <= 1'b0;
      r_vsync_d  <= 1'b0;
      r_evt_stat <= '0;
      r_evt_en   <= '0;
      r_rd       <= '0;
      r_rd_valid <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CTRL; k++) begin
        if (iWE_BIT[k]) r_ctrl[k] <= iDATA;
      end
      if (w_load) begin
        for (int s = 0; s < NUM_STAT; s++) r_shadow[s] <= iSTAT[s*STAT_WIDTH +: STAT_WIDTH];
      end
      // A second VSYNC while a snapshot is already pending is simply absorbed.
      if (!r_lock)     r_pending <= 1'b0;
      else if (w_edge) r_pending <= 1'b1;
      if (w_lock_set) begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_lock_set_idx;
      end else if (w_lock_clr) begin
        r_lock     <= 1'b0;
      end
      r_vsync_d  <= iVSYNC;
      r_evt_stat <= (r_evt_stat & ~w_evt_clr) | iEVT;
      if (iWE_BIT[EVT_EN_IDX]) r_evt_en <= iDATA[NUM_EVT-1:0];
      r_rd       <= w_rd;
      r_rd_valid <= |iRE_BIT;
      r_irq      <= |(r_evt_stat & r_evt_en);
    end
  end

  assign oRD       = r_rd;
  assign oRD_VALID = r_rd_valid;
  assign oIRQ      = r_irq;

endmodule

// File: tb/tb_eye_tracker_reg_bank.sv
// Directed plus randomized bench for eye_tracker_reg_bank, checked against an
// array-based register-map model evaluated once per clock.
module tb_eye_tracker_reg_bank;

  localparam int DW = 8;
  localparam int NC = 4;
  localparam int NS = 7;
  localparam int SW = 28;
  localparam int NE = 4;
  localparam int B  = 4;
  localparam int RC = NC + NS*B + 2;
  localparam logic [31:0] CINIT = 32'h0101_0100;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [RC-1:0] iWE_BIT, iRE_BIT;
  logic [DW-1:0] iDATA, oRD;
  logic          oRD_VALID, iVSYNC, oIRQ;
  logic [NS*SW-1:0] iSTAT;
  logic [NE-1:0] iEVT;
  logic [NC*DW-1:0] oCTRL;

  eye_tracker_reg_bank dut (
    .CLK(CLK), .RST_N(RST_N), .iWE_BIT(iWE_BIT), .iRE_BIT(iRE_BIT),
    .iDATA(iDATA), .oRD(oRD), .oRD_VALID(oRD_VALID), .iVSYNC(iVSYNC),
    .iSTAT(iSTAT), .iEVT(iEVT), .oCTRL(oCTRL), .oIRQ(oIRQ)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [7:0]  m_ctrl   [NC];
  logic [27:0] m_shadow [NS];
  logic [27:0] live     [NS];
  bit          m_lock, m_pend, m_vs;
  int          m_lidx;
  logic [3:0]  m_evt, m_en;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NC; k++) m_ctrl[k] = CINIT[k*8 +: 8];
    for (int s = 0; s < NS; s++) m_shadow[s] = '0;
    m_lock = 0; m_pend = 0; m_vs = 0; m_lidx = 0;
    m_evt = '0; m_en = '0;
  endtask

  function automatic logic [7:0] reg_val(input int idx);
    logic [31:0] tmp;
    if (idx < NC) return m_ctrl[idx];
    if (idx < NC + NS*B) begin
      tmp = {4'b0, m_shadow[(idx-NC)/B]} >> (8*((idx-NC)%B));
      return tmp[7:0];
    end
    if (idx == RC-2) return {4'b0, m_evt};
    return {4'b0, m_en};
  endfunction

  // One clock: predict outputs from the pre-edge model state, then advance the model.
  task automatic tick();
    logic [7:0]  exp_rd;
    logic        exp_vld, exp_irq, edge_v, new_lock;
    logic [31:0] exp_ctrl;
    int          new_lidx, s, b;
    for (int k = 0; k < NS; k++) iSTAT[k*SW +: SW] = live[k];
    exp_rd = '0; exp_vld = 0;
    for (int i = 0; i < RC; i++) if (iRE_BIT[i]) begin exp_rd |= reg_val(i); exp_vld = 1; end
    exp_irq = |(m_evt & m_en);
    edge_v = iVSYNC && !m_vs;
    new_lock = m_lock; new_lidx = m_lidx;
    for (int i = NC; i < NC + NS*B; i++) if (iRE_BIT[i]) begin
      s = (i-NC)/B; b = (i-NC)%B;
      if (b == 0) begin new_lock = 1; new_lidx = s; end
      else if (b == B-1 && m_lock && s == m_lidx) new_lock = 0;
    end
    if (!m_lock) begin
      if (edge_v || m_pend) for (int k = 0; k < NS; k++) m_shadow[k] = live[k];
      m_pend = 0;
    end else if (edge_v) m_pend = 1;
    m_lock = new_lock; m_lidx = new_lidx;
    m_evt = (m_evt & ~(iWE_BIT[RC-2] ? iDATA[3:0] : 4'h0)) | iEVT;
    if (iWE_BIT[RC-1]) m_en = iDATA[3:0];
    for (int k = 0; k < NC; k++) if (iWE_BIT[k]) m_ctrl[k] = iDATA;
    m_vs = iVSYNC;
    for (int k = 0; k < NC; k++) exp_ctrl[k*8 +: 8] = m_ctrl[k];
    @(posedge CLK);
    #1;
    check("rd", {24'b0, oRD}, {24'b0, exp_rd});
    check("rd_vld", {31'b0, oRD_VALID}, {31'b0, exp_vld});
    check("irq", {31'b0, oIRQ}, {31'b0, exp_irq});
    check("ctrl", oCTRL, exp_ctrl);
  endtask

  task automatic set_idle();
    iWE_BIT = '0; iRE_BIT = '0; iDATA = '0; iEVT = '0;
  endtask

  task automatic rd(input int idx);
    set_idle(); iRE_BIT[idx] = 1'b1; tick();
  endtask

  task automatic wr(input int idx, input logic [7:0] d);
    set_idle(); iWE_BIT[idx] = 1'b1; iDATA = d; tick();
  endtask

  task automatic idle();
    set_idle(); tick();
  endtask

  task automatic vsync_pulse();
    set_idle(); iVSYNC = 1'b1; tick(); iVSYNC = 1'b0; tick();
  endtask

  initial begin
    set_idle();
    iVSYNC = 1'b0;
    for (int k = 0; k < NS; k++) live[k] = '0;
    iSTAT = '0;
    RST_N = 1'b0;
    model_reset();
    #12;
    check("reset_ctrl", oCTRL, 32'h0101_0100);
    check("reset_irq", {31'b0, oIRQ}, 32'd0);
    check("reset_rd", {24'b0, oRD}, 32'd0);
    check("reset_vld", {31'b0, oRD_VALID}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    rd(33);
    check("t1_rd33", {24'b0, oRD}, 32'h00);
    check("t1_vld", {31'b0, oRD_VALID}, 32'd1);
    idle();
    check("t1_vld_drop", {31'b0, oRD_VALID}, 32'd0);

    wr(2, 8'hA5);
    check("t2_ctrl2", {24'b0, oCTRL[23:16]}, 32'hA5);
    rd(2);
    check("t2_rd2", {24'b0, oRD}, 32'hA5);
    wr(5, 8'hFF);
    rd(5);
    check("t2_stat_wr_ignored", {24'b0, oRD}, 32'h00);

    live[0] = 28'h123_4567;
    vsync_pulse();
    live[0] = '0;
    rd(4); check("t3_b0", {24'b0, oRD}, 32'h67);
    rd(5); check("t3_b1", {24'b0, oRD}, 32'h45);
    rd(6); check("t3_b2", {24'b0, oRD}, 32'h23);
    rd(7); check("t3_b3", {24'b0, oRD}, 32'h01);

    rd(4); check("t4_lock_b0", {24'b0, oRD}, 32'h67);
    live[0] = 28'hABC_DEF0;
    vsync_pulse();
    rd(5); check("t4_locked_b1", {24'b0, oRD}, 32'h45);
    rd(7); check("t4_release_b3", {24'b0, oRD}, 32'h01);
    idle();
    rd(4); check("t4_new_b0", {24'b0, oRD}, 32'hF0);
    rd(7); check("t4_new_b3", {24'b0, oRD}, 32'h0A);

    wr(33, 8'h02);
    set_idle(); iEVT = 4'b0010; tick();
    rd(32);
    check("t5_evt_set", {24'b0, oRD}, 32'h02);
    check("t5_irq_on", {31'b0, oIRQ}, 32'd1);
    wr(32, 8'h02);
    idle();
    check("t5_irq_off", {31'b0, oIRQ}, 32'd0);
    rd(32); check("t5_evt_clr", {24'b0, oRD}, 32'h00);
    set_idle(); iWE_BIT[32] = 1'b1; iDATA = 8'h02; iEVT = 4'b0010; tick();
    rd(32);
    check("t5_set_wins", {24'b0, oRD}, 32'h02);
    check("t5_set_wins_irq", {31'b0, oIRQ}, 32'd1);
    wr(32, 8'hFF);
    idle();

    wr(0, 8'h3C);
    live[0] = 28'h111_2222;
    vsync_pulse();
    rd(4);
    live[0] = 28'h333_4444;
    vsync_pulse();
    #2;
    RST_N = 1'b0;
    #1;
    model_reset();
    check("t6_ctrl", oCTRL, 32'h0101_0100);
    check("t6_irq", {31'b0, oIRQ}, 32'd0);
    check("t6_rd", {24'b0, oRD}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    rd(5); check("t6_shadow_clr", {24'b0, oRD}, 32'h00);
    live[0] = 28'hFED_CBA9;
    vsync_pulse();
    rd(5); check("t6_snap_b1", {24'b0, oRD}, 32'hCB);
    rd(7); check("t6_snap_b3", {24'b0, oRD}, 32'h0F);

    for (int n = 0; n < 600; n++) begin
      int r;
      set_idle();
      r = $urandom_range(0, 9);
      if (r < 5) iRE_BIT[$urandom_range(0, RC-1)] = 1'b1;
      else if (r < 8) begin
        iWE_BIT[$urandom_range(0, RC-1)] = 1'b1;
        iDATA = 8'($urandom);
      end
      iVSYNC = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) live[$urandom_range(0, NS-1)] = 28'($urandom);
      if ($urandom_range(0, 5) == 0) iEVT = 4'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
